// File: rtl/reduction_result_packer.sv
// Packs 1-bit OR-tree results LSB-first into OUT_WIDTH-bit words, buffers
// them in a small FIFO and hands them to the NoC side with valid/ready.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   i_en, i_valid, i_data_bus     qualified reduced-result input
//   i_flush                       emit the current partial word
//   o_in_ready                    input can be accepted this cycle
//   o_overflow                    registered pulse for each dropped result
//   o_valid, i_ready              output handshake
//   o_data_bus, o_count           packed word and its number of valid bits
module reduction_result_packer #(
    parameter int OUT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_en,
    input  logic                           i_valid,
    input  logic                           i_data_bus,
    input  logic                           i_flush,
    output logic                           o_in_ready,
    output logic                           o_overflow,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [OUT_WIDTH-1:0]           o_data_bus,
    output logic [$clog2(OUT_WIDTH+1)-1:0] o_count
);
    localparam int CW = $clog2(OUT_WIDTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    logic [CW-1:0]        cnt_q, cnt_d, eff_cnt;
    logic [OUT_WIDTH-1:0] acc_q, acc_d, word;
    logic                 flush_pend_q, flush_pend_d;
    logic                 ovf_q;
    logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]        occ_q;
    logic [OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
    logic [CW-1:0]        mem_cnt  [FIFO_DEPTH];
    logic                 full, empty;
    logic                 accept, drop, flush_req;
    logic                 push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full       = (occ_q == OW'(FIFO_DEPTH));
    assign empty      = (occ_q == '0);
    assign o_in_ready = !rst && !full;

    assign accept    = i_en && i_valid && o_in_ready;
    assign drop      = i_en && i_valid && !o_in_ready;
    assign flush_req = flush_pend_q || (i_en && i_flush);

    // Bits above cnt_q are always zero, so OR-ing in the new bit is enough.
    assign eff_cnt = cnt_q + CW'(accept);
    assign word    = acc_q | (OUT_WIDTH'(accept & i_data_bus) << cnt_q);

    assign pop = !empty && i_ready;

    always_comb begin
        push         = 1'b0;
        cnt_d        = cnt_q;
        acc_d        = acc_q;
        flush_pend_d = flush_req && full;
        if (accept) begin
            cnt_d = eff_cnt;
            acc_d = word;
        end
        // A completing word absorbs a coincident flush: no empty word follows.
        if (eff_cnt == CW'(OUT_WIDTH)) begin
            push = 1'b1;
        end else if (flush_req && !full && eff_cnt != '0) begin
            push = 1'b1;
        end
        if (push) begin
            cnt_d = '0;
            acc_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= '0;
            acc_q        <= '0;
            flush_pend_q <= 1'b0;
            ovf_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
        end else begin
            cnt_q        <= cnt_d;
            acc_q        <= acc_d;
            flush_pend_q <= flush_pend_d;
            ovf_q        <= drop;
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                occ_q <= occ_q + 1'b1;
            end else if (pop && !push) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr_q] <= word;
            mem_cnt[wr_ptr_q]  <= eff_cnt;
        end
    end

    assign o_valid    = !empty && !rst;
    assign o_data_bus = o_valid ? mem_data[rd_ptr_q] : '0;
    assign o_count    = o_valid ? mem_cnt[rd_ptr_q] : '0;
    assign o_overflow = ovf_q && !rst;

endmodule
